// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream (high byte first),
// assembles 16-bit words and writes them to consecutive IMemory addresses
// while holding the CPU.
// Optional feature macro: LOADER_CHECKSUM_EN. When defined, two trailing
// bytes carry a 16-bit checksum, which is compared against the running sum
// of the written words.
//
// state | meaning
// IDLE  | waiting for start after reset
// RX_HI | waiting for the high byte of the next word
// RX_LO | waiting for the low byte of the next word
// WRITE | one-cycle write strobe to instruction memory
// CK_HI | waiting for the checksum high byte (checksum build only)
// CK_LO | waiting for the checksum low byte (checksum build only)
// DONE  | load complete, done held until the next accepted start
module imem_loader (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic [10:0] word_cnt,
  output logic        cksum_err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, RX_HI, RX_LO, WRITE, CK_HI, CK_LO, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RX_HI, RX_LO, WRITE, DONE
  } state_t;
`endif

  state_t      state;
  logic [10:0] count_q;
  logic [7:0]  hi_byte;
  logic [10:0] count_clamp;
  logic [11:0] cnt_plus1;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum;
  logic [7:0]  ck_hi;
`endif

  // Loads longer than the 1024-word memory are truncated to fit it.
  assign count_clamp = (count > 11'd1024) ? 11'd1024 : count;
  assign cnt_plus1   = {1'b0, word_cnt} + 12'd1;

`ifndef LOADER_CHECKSUM_EN
  assign cksum_err = 1'b0;
`endif

  // Loader FSM; all outputs are registered and set on state transitions.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count_q   <= '0;
      hi_byte   <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      word_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum       <= '0;
      ck_hi     <= '0;
      cksum_err <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            count_q  <= count_clamp;
            word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
            cksum_err <= 1'b0;
`endif
            if (count_clamp != 11'd0) begin
              state    <= RX_HI;
              in_ready <= 1'b1;
              cpu_hold <= 1'b1;
              done     <= 1'b0;
            end else begin
              // Empty load completes immediately without holding the CPU.
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RX_HI: begin
          if (in_valid) begin
            hi_byte <= in_data;
            state   <= RX_LO;
          end
        end
        RX_LO: begin
          if (in_valid) begin
            mem_wdata <= {hi_byte, in_data};
            mem_addr  <= word_cnt[9:0];
            mem_we    <= 1'b1;
            in_ready  <= 1'b0;
            state     <= WRITE;
          end
        end
        WRITE: begin
          word_cnt <= cnt_plus1[10:0];
`ifdef LOADER_CHECKSUM_EN
          sum <= sum + mem_wdata;
`endif
          if (cnt_plus1 < {1'b0, count_q}) begin
            state    <= RX_HI;
            in_ready <= 1'b1;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            state    <= CK_HI;
            in_ready <= 1'b1;
`else
            state    <= DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CK_HI: begin
          if (in_valid) begin
            ck_hi <= in_data;
            state <= CK_LO;
          end
        end
        CK_LO: begin
          if (in_valid) begin
            cksum_err <= ({ck_hi, in_data} != sum);
            in_ready  <= 1'b0;
            cpu_hold  <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte/word-level reference model
// predicts the outputs every cycle; directed loads pin literal results.
module tb_imem_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] count = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_we, cpu_hold, done, cksum_err;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [10:0] word_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] tbmem [0:1023];
  int          wr_total = 0;
  logic [7:0]  tx_q [$];

  imem_loader dut (
    .clock(clock), .reset(reset), .start(start), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .word_cnt(word_cnt),
    .cksum_err(cksum_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the load as byte/word transactions.
  bit          m_valid = 1'b0;
  bit          m_active, m_wr, m_ck, m_done, m_err, m_nb;
  int          m_target, m_writes;
  logic [7:0]  m_hi, m_ckhi;
  logic [15:0] m_word, m_sum;

  // Compare DUT outputs against the model, then advance the model with the
  // inputs the DUT will sample on the coming rising edge.
  always @(negedge clock) begin
    if (m_valid) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_active && !m_wr});
      chk("mem_we", {31'b0, mem_we}, {31'b0, m_wr});
      if (m_wr) begin
        chk("mem_addr", {22'b0, mem_addr}, 32'(m_writes));
        chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, m_word});
      end
      chk("cpu_hold", {31'b0, cpu_hold}, {31'b0, m_active});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("word_cnt", {21'b0, word_cnt}, 32'(m_writes));
      chk("cksum_err", {31'b0, cksum_err}, {31'b0, m_err});
    end
    if (mem_we === 1'b1) begin
      tbmem[mem_addr] = mem_wdata;
      wr_total++;
    end
    if (reset) begin
      m_valid = 1'b1; m_active = 0; m_wr = 0; m_ck = 0; m_done = 0;
      m_err = 0; m_nb = 0; m_target = 0; m_writes = 0; m_sum = '0;
    end else if (m_valid) begin
      if (!m_active) begin
        if (start) begin
          m_target = (count > 11'd1024) ? 1024 : int'(count);
          m_writes = 0; m_sum = '0; m_err = 0; m_nb = 0; m_ck = 0;
          m_done = (m_target == 0);
          m_active = (m_target != 0);
        end
      end else if (m_wr) begin
        m_wr = 0;
        m_writes++;
        m_sum = m_sum + m_word;
        if (m_writes == m_target) begin
          if (CK_EN) m_ck = 1;
          else begin m_active = 0; m_done = 1; end
        end
      end else if (in_valid) begin
        if (m_ck) begin
          if (!m_nb) begin m_ckhi = in_data; m_nb = 1; end
          else begin
            m_err = ({m_ckhi, in_data} != m_sum);
            m_nb = 0; m_ck = 0; m_active = 0; m_done = 1;
          end
        end else if (!m_nb) begin
          m_hi = in_data; m_nb = 1;
        end else begin
          m_word = {m_hi, in_data}; m_nb = 0; m_wr = 1;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax, input bit noise);
    int g;
    int k;
    g = $urandom_range(gmax, gmin);
    repeat (g) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      start    = noise && ($urandom_range(3, 0) == 0);
      count    = 11'($urandom_range(2047, 0));
      @(posedge clock); #1;
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (k = 0; k < 200; k++) begin
      @(negedge clock);
      if (in_ready === 1'b1) break;
    end
    if (k == 200) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clock);
      if (done === 1'b1) break;
    end
    if (k == 50) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Full load: uses bytes queued in tx_q, pads with random bytes.
  task automatic run_load(input int cnt, input int gmin, input int gmax,
                          input bit noise, input bit bad_ck);
    int nw;
    int base;
    logic [15:0] s;
    logic [15:0] ck;
    nw = (cnt > 1024) ? 1024 : cnt;
    base = wr_total;
    s = '0;
    while (tx_q.size() < 2 * nw) tx_q.push_back(8'($urandom));
    for (int i = 0; i < nw; i++) s = s + {tx_q[2*i], tx_q[2*i+1]};
    start = 1'b1; count = 11'(cnt);
    @(posedge clock); #1;
    start = 1'b0; count = 11'($urandom_range(2047, 0));
    for (int i = 0; i < 2 * nw; i++) send_byte(tx_q[i], gmin, gmax, noise);
    if (CK_EN && nw != 0) begin
      ck = bad_ck ? s + 16'd1 : s;
      send_byte(ck[15:8], gmin, gmax, noise);
      send_byte(ck[7:0], gmin, gmax, noise);
    end
    wait_done();
    chk("load_done", {31'b0, done}, 32'd1);
    chk("load_word_cnt", {21'b0, word_cnt}, 32'(nw));
    chk("load_writes", 32'(wr_total - base), 32'(nw));
    chk("load_cksum_err", {31'b0, cksum_err}, {31'b0, CK_EN && bad_ck && nw != 0});
    tx_q.delete();
  endtask

  initial begin
    int base;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
    chk("rst_cpu_hold", {31'b0, cpu_hold}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_word_cnt", {21'b0, word_cnt}, 32'd0);
    chk("rst_cksum_err", {31'b0, cksum_err}, 32'd0);
    @(posedge clock); #1;

    // Two words, continuous stream.
    tx_q = '{8'h81, 8'h09, 8'h9A, 8'h04};
    run_load(2, 0, 0, 0, 0);
    chk("two_word_w0", {16'b0, tbmem[0]}, 32'h8109);
    chk("two_word_w1", {16'b0, tbmem[1]}, 32'h9A04);

    // Empty load: done the very next cycle, no write.
    base = wr_total;
    start = 1'b1; count = 11'd0;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("zero_done", {31'b0, done}, 32'd1);
    chk("zero_hold", {31'b0, cpu_hold}, 32'd0);
    chk("zero_writes", 32'(wr_total - base), 32'd0);
    @(posedge clock); #1;

    // Single word with a five-cycle stall on the stream.
    tx_q = '{8'hA6, 8'h02};
    run_load(1, 5, 5, 0, 0);
    chk("stall_w0", {16'b0, tbmem[0]}, 32'hA602);

    // Reset while waiting for the low byte of word 1.
    tbmem[1] = 16'hDEAD;
    base = wr_total;
    start = 1'b1; count = 11'd3;
    @(posedge clock); #1;
    start = 1'b0;
    send_byte(8'h11, 0, 0, 0);
    send_byte(8'h22, 0, 0, 0);
    send_byte(8'h33, 0, 0, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_hold", {31'b0, cpu_hold}, 32'd0);
    chk("abort_ready", {31'b0, in_ready}, 32'd0);
    chk("abort_word_cnt", {21'b0, word_cnt}, 32'd0);
    chk("abort_writes", 32'(wr_total - base), 32'd1);
    chk("abort_w0", {16'b0, tbmem[0]}, 32'h1122);
    chk("abort_w1", {16'b0, tbmem[1]}, 32'hDEAD);
    @(posedge clock); #1;
    tx_q = '{8'h5A, 8'h3C};
    run_load(1, 0, 0, 0, 0);
    chk("reload_w0", {16'b0, tbmem[0]}, 32'h5A3C);

    // Start pulses while busy are ignored.
    tx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_load(2, 1, 2, 1, 0);
    chk("busy_start_w1", {16'b0, tbmem[1]}, 32'h5678);

    if (CK_EN) begin
      tx_q = '{8'hFF, 8'hFF, 8'h00, 8'h02};
      run_load(2, 0, 0, 0, 0);
      chk("ck_good_err", {31'b0, cksum_err}, 32'd0);
      tx_q = '{8'hFF, 8'hFF, 8'h00, 8'h02};
      run_load(2, 0, 0, 0, 1);
      chk("ck_bad_err", {31'b0, cksum_err}, 32'd1);
    end

    // Oversized count is clamped to the full memory.
    run_load(1100, 0, 0, 0, 0);
    chk("clamp_cnt", {21'b0, word_cnt}, 32'd1024);

    // Randomized loads with stalls and spurious starts.
    repeat (14) run_load($urandom_range(12, 1), 0, 3, 1, 1'($urandom));

    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
